// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters with a round-robin grant.
// Optional macro ALU_ARB_FIXED_PRIORITY_EN: requester 0 wins every contested grant.
// Opcodes: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, 5 SLL by b[log2(DATA_W)-1:0].
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MAX_OP = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              rsp_negative,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);
    localparam int unsigned OP_W = 4;
    localparam int unsigned SH_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [4:0]        rsp_flags_q, rsp_flags_d;  // {err, overflow, negative, zero, carry}
    logic [CNT_W-1:0]  ops_done_q, ops_done_d;

    logic              grant;
    logic              accept;
    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_overflow;
    logic              alu_illegal;

    // Grant: 0 selects requester 0, 1 selects requester 1
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && !rst && !grant;
    assign req1_ready = (state_q == IDLE) && !rst && grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // The ALU sees only the operand registers, so requester inputs may change after accept
    always_comb begin
        alu_wide     = '0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_illegal  = (op_q > OP_W'(MAX_OP));
        case (op_q)
            4'd0: begin
                alu_wide     = {1'b0, a_q} + {1'b0, b_q};
                alu_result   = alu_wide[DATA_W-1:0];
                alu_carry    = alu_wide[DATA_W];
                alu_overflow = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                               (alu_result[DATA_W-1] != a_q[DATA_W-1]);
            end
            4'd1: begin
                alu_wide     = {1'b0, a_q} - {1'b0, b_q};
                alu_result   = alu_wide[DATA_W-1:0];
                alu_carry    = alu_wide[DATA_W];
                alu_overflow = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                               (alu_result[DATA_W-1] != a_q[DATA_W-1]);
            end
            4'd2:    alu_result = a_q & b_q;
            4'd3:    alu_result = a_q | b_q;
            4'd4:    alu_result = a_q ^ b_q;
            4'd5:    alu_result = a_q << b_q[SH_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, response capture and completion counting
    always_comb begin
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        ops_done_d   = ops_done_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d          = grant ? req1_a : req0_a;
                    b_d          = grant ? req1_b : req0_b;
                    op_d         = grant ? req1_op : req0_op;
                    id_d         = grant;
                    last_grant_d = grant;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                if (alu_illegal) begin
                    rsp_result_d = '0;
                    rsp_flags_d  = 5'b10000;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = {1'b0, alu_overflow, alu_result[DATA_W-1],
                                    (alu_result == '0), alu_carry};
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            ops_done_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_flags_q[0];
    assign rsp_zero     = rsp_flags_q[1];
    assign rsp_negative = rsp_flags_q[2];
    assign rsp_overflow = rsp_flags_q[3];
    assign rsp_err      = rsp_flags_q[4];
    assign busy         = (state_q != IDLE);
    assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized bench for alu_arbiter, checked against a transaction-level reference model.
// A second instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_alu_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [4:0]        f;  // {carry, zero, negative, overflow, err}
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]        req0_op = '0, req1_op = '0;
    logic              rsp_valid, rsp_id;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_err, busy;
    logic [CNT_W-1:0]  ops_done;

    logic              s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
    logic [DATA_W-1:0] s_rsp_result;
    logic              s_carry, s_zero, s_negative, s_overflow, s_err, s_busy;
    logic [3:0]        s_ops_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic exp_last = 1'b1;
    int exp_ops = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_OP(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
        .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.DATA_W(DATA_W), .CNT_W(4), .MAX_OP(5)) u_small (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_result(s_rsp_result),
        .rsp_carry(s_carry), .rsp_zero(s_zero), .rsp_negative(s_negative),
        .rsp_overflow(s_overflow), .rsp_err(s_err), .busy(s_busy), .ops_done(s_ops_done)
    );

    // Reference ALU: plain 64-bit arithmetic with range checks for signed overflow
    function automatic exp_t ref_alu(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [3:0] op);
        exp_t e;
        longint sr;
        logic c, v, err;
        c = 1'b0; v = 1'b0; err = 1'b0; e.r = '0;
        case (op)
            4'd0: begin
                e.r = a + b;
                c   = (longint'(a) + longint'(b)) > 64'sd4294967295;
                sr  = longint'($signed(a)) + longint'($signed(b));
                v   = (sr > SMAX) || (sr < SMIN);
            end
            4'd1: begin
                e.r = a - b;
                c   = (a < b);
                sr  = longint'($signed(a)) - longint'($signed(b));
                v   = (sr > SMAX) || (sr < SMIN);
            end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = a << b[4:0];
            default: err = 1'b1;
        endcase
        e.f = {c, (!err && e.r == '0), e.r[DATA_W-1], v, err};
        return e;
    endfunction

    // Arbitration rule: lone requester wins; a contest goes to the one not granted last
    function automatic int arb_model(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            return 0;
`else
            return exp_last ? 0 : 1;
`endif
        end
        return v1 ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_last = 1'b1;
        exp_ops = 0;
    endtask

    // Returns the requester accepted on the next accepting edge, or -1 after the cycle budget
    task automatic wait_grant(output int gid);
        gid = -1;
        for (int i = 0; i < 30 && gid < 0; i++) begin
            #1;
            if (req0_valid && req0_ready) gid = 0;
            else if (req1_valid && req1_ready) gid = 1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        tick(); tick();
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
            $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== '0) begin bad++;
            $display("FAIL reset_state got valid=%b busy=%b ops=%0d exp 0 0 0", rsp_valid, busy, ops_done); end
        total++; if (rsp_result !== '0 || rsp_id !== 1'b0 ||
                     {rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_err} !== 5'b0) begin bad++;
            $display("FAIL reset_rsp got result=%h id=%b exp 0 0", rsp_result, rsp_id); end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++;
            $display("FAIL lone_req1_ready got=%b%b exp=01", req0_ready, req1_ready); end
        req1_valid = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++;
            $display("FAIL dropped_valid got busy=%b exp=0", busy); end
        exp_last = 1'b1;
        exp_ops = 0;
    endtask

    task automatic test_basic();
        int g;
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd0;
        wait_grant(g);
        total++; if (g !== 0) begin bad++; $display("FAIL basic_grant got=%0d exp=0", g); end
        exp_last = 1'b0;
        req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 5));
        total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++;
            $display("FAIL basic_exec got busy=%b valid=%b exp 1 0", busy, rsp_valid); end
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12) begin bad++;
            $display("FAIL basic_result got valid=%b result=%0d exp 1 12", rsp_valid, rsp_result); end
        total++; if (rsp_id !== 1'b0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin bad++;
            $display("FAIL basic_flags got id=%b zero=%b err=%b exp 0 0 0", rsp_id, rsp_zero, rsp_err); end
        tick();
        exp_ops++;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== CNT_W'(exp_ops)) begin bad++;
            $display("FAIL basic_done got valid=%b busy=%b ops=%0d exp 0 0 %0d", rsp_valid, busy, ops_done, exp_ops); end
    endtask

    task automatic test_round_robin();
        int g, eg, prev;
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = 4'd1;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3; req1_op = 4'd1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            eg = arb_model(1'b1, 1'b1);
            wait_grant(g);
            total++; if (g !== eg) begin bad++; $display("FAIL rr_grant op=%0d got=%0d exp=%0d", k, g, eg); end
            if (k > 0) begin
                total++; if (cyc - prev !== 3) begin bad++;
                    $display("FAIL rr_spacing got=%0d exp=3", cyc - prev); end
            end
            prev = cyc;
            exp_last = eg[0];
            tick();
            exp_ops++;
            total++; if (rsp_valid !== 1'b1 || rsp_result !== '0 || rsp_zero !== 1'b1 || rsp_id !== eg[0]) begin bad++;
                $display("FAIL rr_rsp got valid=%b result=%h zero=%b id=%b exp 1 0 1 %0d",
                         rsp_valid, rsp_result, rsp_zero, rsp_id, eg); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        total++; if (ops_done !== CNT_W'(exp_ops) || busy !== 1'b0) begin bad++;
            $display("FAIL rr_count got ops=%0d busy=%b exp %0d 0", ops_done, busy, exp_ops); end
    endtask

    task automatic test_illegal();
        int g;
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 4'd9;
        wait_grant(g);
        total++; if (g !== 1) begin bad++; $display("FAIL illegal_grant got=%0d exp=1", g); end
        exp_last = 1'b1;
        req1_valid = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== '0 || rsp_id !== 1'b1) begin bad++;
            $display("FAIL illegal_rsp got valid=%b err=%b result=%h id=%b exp 1 1 0 1",
                     rsp_valid, rsp_err, rsp_result, rsp_id); end
        total++; if ({rsp_carry, rsp_zero, rsp_negative, rsp_overflow} !== 4'b0) begin bad++;
            $display("FAIL illegal_flags got=%b exp=0000", {rsp_carry, rsp_zero, rsp_negative, rsp_overflow}); end
        tick();
        exp_ops++;
        total++; if (ops_done !== CNT_W'(exp_ops)) begin bad++;
            $display("FAIL illegal_count got=%0d exp=%0d", ops_done, exp_ops); end
    endtask

    task automatic test_stall();
        int g;
        exp_t e;
        rsp_ready = 1'b0;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 5));
        e = ref_alu(req0_a, req0_b, req0_op);
        wait_grant(g);
        total++; if (g !== 0) begin bad++; $display("FAIL stall_grant got=%0d exp=0", g); end
        exp_last = 1'b0;
        req1_valid = 1'b1; req1_a = $urandom; req1_op = 4'd0;
        tick();
        for (int s = 0; s < 5; s++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_result !== e.r || rsp_id !== 1'b0 ||
                         {rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_err} !== e.f) begin bad++;
                $display("FAIL stall_hold cycle=%0d got valid=%b result=%h id=%b exp 1 %h 0", s, rsp_valid, rsp_result, rsp_id, e.r); end
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || ops_done !== CNT_W'(exp_ops)) begin bad++;
                $display("FAIL stall_ready got=%b%b ops=%0d exp 00 %0d", req0_ready, req1_ready, ops_done, exp_ops); end
            tick();
        end
        rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        exp_ops++;
        total++; if (rsp_valid !== 1'b0 || ops_done !== CNT_W'(exp_ops)) begin bad++;
            $display("FAIL stall_release got valid=%b ops=%0d exp 0 %0d", rsp_valid, ops_done, exp_ops); end
        tick();
        total++; if (busy !== 1'b0 || ops_done !== CNT_W'(exp_ops)) begin bad++;
            $display("FAIL stall_once got busy=%b ops=%0d exp 0 %0d", busy, ops_done, exp_ops); end
    endtask

    task automatic test_reset_in_resp();
        int g;
        exp_t e;
        do_reset();
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 4'd0;
        wait_grant(g);
        total++; if (g !== 0) begin bad++; $display("FAIL rstresp_grant got=%0d exp=0", g); end
        req0_valid = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rstresp_pre got valid=%b exp=1", rsp_valid); end
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 5));
        e = ref_alu(req1_a, req1_b, req1_op);
        rst = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
            $display("FAIL rstresp_ready got=%b%b exp=00", req0_ready, req1_ready); end
        tick();
        rst = 1'b0;
        exp_last = 1'b1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== CNT_W'(exp_ops)) begin bad++;
            $display("FAIL rstresp_discard got valid=%b busy=%b ops=%0d exp 0 0 %0d", rsp_valid, busy, ops_done, exp_ops); end
        rsp_ready = 1'b1;
        wait_grant(g);
        total++; if (g !== 1) begin bad++; $display("FAIL rstresp_pending got=%0d exp=1", g); end
        exp_last = 1'b1;
        req1_valid = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== e.r) begin bad++;
            $display("FAIL rstresp_rsp got valid=%b id=%b result=%h exp 1 1 %h", rsp_valid, rsp_id, rsp_result, e.r); end
        tick();
        exp_ops++;
        total++; if (ops_done !== CNT_W'(exp_ops)) begin bad++;
            $display("FAIL rstresp_count got=%0d exp=%0d", ops_done, exp_ops); end
    endtask

    task automatic test_random();
        int g, eg, stall, pat;
        logic v0, v1;
        exp_t e;
        for (int n = 0; n < 150; n++) begin
            pat = $urandom_range(1, 3);
            v0 = pat[0]; v1 = pat[1];
            req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            req0_op = 4'($urandom_range(0, 7)); req1_op = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) req0_op = 4'd15;
            req0_valid = v0; req1_valid = v1;
            stall = $urandom_range(0, 3);
            rsp_ready = (stall == 0);
            eg = arb_model(v0, v1);
            e = (eg == 1) ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
            wait_grant(g);
            total++; if (g !== eg) begin bad++; $display("FAIL rand_grant txn=%0d got=%0d exp=%0d", n, g, eg); end
            exp_last = eg[0];
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_a = $urandom; req1_b = $urandom; req0_op = 4'($urandom); req1_op = 4'($urandom);
            tick();
            for (int s = 0; s <= stall; s++) begin
                total++; if (rsp_valid !== 1'b1 || rsp_result !== e.r || rsp_id !== eg[0] ||
                             {rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_err} !== e.f) begin bad++;
                    $display("FAIL rand_rsp txn=%0d got valid=%b result=%h id=%b flags=%b exp 1 %h %0d %b", n, rsp_valid,
                             rsp_result, rsp_id, {rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_err}, e.r, eg, e.f); end
                total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
                    $display("FAIL rand_ready txn=%0d got=%b%b exp=00", n, req0_ready, req1_ready); end
                if (s < stall) tick();
            end
            rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
            tick();
            exp_ops++;
            total++; if (rsp_valid !== 1'b0 || ops_done !== CNT_W'(exp_ops)) begin bad++;
                $display("FAIL rand_done txn=%0d got valid=%b ops=%0d exp 0 %0d", n, rsp_valid, ops_done, exp_ops); end
        end
    endtask

    task automatic test_wrap();
        int g;
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd0;
        for (int k = 0; k < 16; k++) begin
            wait_grant(g);
            total++; if (g !== 0 || s_ops_done !== 4'(k)) begin bad++;
                $display("FAIL wrap_step k=%0d got grant=%0d small_ops=%0d exp 0 %0d", k, g, s_ops_done, k); end
            tick();
            exp_ops++;
        end
        req0_valid = 1'b0;
        tick();
        total++; if (s_ops_done !== 4'd0) begin bad++;
            $display("FAIL wrap_small got=%0d exp=0", s_ops_done); end
        total++; if (ops_done !== CNT_W'(exp_ops)) begin bad++;
            $display("FAIL wrap_big got=%0d exp=%0d", ops_done, exp_ops); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle=%0d total=%0d bad=%0d", cyc, total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_illegal();
        test_stall();
        test_reset_in_resp();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
